gate_controller: RTL and testbench
==================================

# gate_controller

Front-end gate controller for the parking management system. It debounces the raw entry and exit car sensors and serialises them into single-cycle `entry_signal` / `exit_signal` requests, with `exit_slot`, toward the parking occupancy FSM. It then consumes that FSM's `is_open` / `is_full` response, drives the barrier motor for a fixed hold time and lights the full lamp on rejected entries.

## Interface
Parameters:
- `DEBOUNCE`, default 4: consecutive identical samples needed to accept a sensor level. Legal range 1..15.
- `DOOR_HOLD`, default 8: cycles `gate_motor` stays high per accepted request. Legal range 1..255.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `entry_sensor`  in  1  raw car-present sensor at the entry lane.
- `exit_sensor`  in  1  raw car-present sensor at the exit lane.
- `exit_request_slot`  in  2  slot number of the departing car, valid with `exit_sensor`.
- `is_open`  in  1  occupancy FSM response: request accepted.
- `is_full`  in  1  occupancy FSM response: entry rejected, lot full.
- `entry_signal`  out  1  one-cycle entry request to the occupancy FSM.
- `exit_signal`  out  1  one-cycle exit request to the occupancy FSM.
- `exit_slot`  out  2  latched exit slot; always driven.
- `gate_motor`  out  1  barrier open command.
- `full_lamp`  out  1  "lot full" indicator.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- **Debounce, per sensor.** A 4-bit counter counts consecutive samples that differ from the current stable level. When it reaches `DEBOUNCE`, the stable level flips and the counter clears. A sample equal to the stable level clears the counter.
- **Pending flags.** A rising stable edge sets `entry_pend` or `exit_pend` on the same edge. On the `exit_pend` set edge, `exit_request_slot` is latched into `exit_slot`, but only if `exit_pend` was clear. Further edges while a flag is already set are dropped, and the slot is not overwritten. Each direction is one deep.
- **State machine:** IDLE, ISSUE, WAIT, OPEN, CLEAR. All outputs are registered.
  - IDLE: if `entry_pend` is set, go to ISSUE(entry); else if `exit_pend` is set, go to ISSUE(exit). Entry has priority.
  - ISSUE, 1 cycle: the matching request output is high and the matching pending flag is cleared. `entry_signal` and `exit_signal` are never high together. Go to WAIT.
  - WAIT, 1 cycle: sample `is_open` / `is_full` at the end of this cycle.
    - `is_open` = 1: load the hold counter with `DOOR_HOLD`, go to OPEN.
    - Else, for an entry with `is_full` = 1: set `full_lamp`, go to IDLE.
    - Else (exit of an empty slot, or no response): go to IDLE without opening.
  - OPEN: `gate_motor` = 1; the counter decrements each cycle. Leave for CLEAR after exactly `DOOR_HOLD` cycles.
  - CLEAR: `gate_motor` = 0. Stay until the stable level of the serving sensor is 0, then go to IDLE. Minimum stay is 1 cycle.
- **Full lamp.** `full_lamp` clears when the entry stable level falls to 0. Reset also clears it.
- **Simultaneous edges.** If entry and exit rise on the same edge, both flags are set. The entry is served first; the exit is served in the next transaction.
- **Width rule.** The hold counter is 8 bits; the debounce counters saturate at `DEBOUNCE`.

## Timing
- **Reset value of all outputs:** 0, including `exit_slot` = 00. Also reset: stable levels 0, counters 0, pending flags 0, state IDLE.
- **Reset mid-operation.** Active-high reset at any edge aborts the transaction. `gate_motor` is 0 and pending requests are discarded from the following cycle.
- **Entry latency.** Raw sensor high from before edge 1 (no glitch): stable level and pending flag rise at edge `DEBOUNCE`. The request output is high from edge `DEBOUNCE`+1 to `DEBOUNCE`+2.
- **FSM handshake.** The occupancy FSM registers its response at the edge closing ISSUE. WAIT samples it at the next edge. The request-to-decision latency is therefore 2 cycles.
- **Gate window.** `gate_motor` is high from edge `DEBOUNCE`+3 to `DEBOUNCE`+3+`DOOR_HOLD`.

## Test plan
The bench models the occupancy FSM: it returns `is_open` or `is_full` for one cycle, one edge after a request. All scenarios use `DEBOUNCE`=4 and `DOOR_HOLD`=8.
1. `entry_sensor` high from edge 1, model returns `is_open` → `entry_signal` high edges 5–6 only; `gate_motor` high edges 7–15; `busy` low again one cycle after the sensor's stable level drops.
2. `entry_sensor` glitch high for 3 cycles → no `entry_signal`, `busy` stays 0, all debounce state returns to 0.
3. Entry with model returning `is_full` → `full_lamp` = 1 from edge 7, `gate_motor` never asserted; `full_lamp` returns to 0 four edges after the sensor drops.
4. `entry_sensor` and `exit_sensor` rise on the same cycle, `exit_request_slot` = 2'b10, both accepted → entry transaction completes first; then `exit_signal` pulses one cycle with `exit_slot` = 2'b10; never both requests high together.
5. Exit request where the model returns neither response → FSM returns to IDLE 2 cycles after `exit_signal`; `gate_motor` stays 0.
6. `reset` asserted in OPEN mid-hold → at the next edge `gate_motor`, `busy` and `exit_slot` are 0; a previously pending exit is not issued after reset releases.

Source files
------------

// File: rtl/gate_controller.sv
// Gate controller front end for the parking management system.
// Debounces the raw entry/exit car sensors, serialises them into one-cycle
// requests toward the occupancy FSM, then drives the barrier motor for a fixed
// hold time or lights the full lamp depending on the occupancy FSM's answer.
module gate_controller #(
    parameter int unsigned DEBOUNCE  = 4,  // 1..15 consecutive samples
    parameter int unsigned DOOR_HOLD = 8   // 1..255 motor cycles
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_sensor,
    input  logic       exit_sensor,
    input  logic [1:0] exit_request_slot,
    input  logic       is_open,
    input  logic       is_full,
    output logic       entry_signal,
    output logic       exit_signal,
    output logic [1:0] exit_slot,
    output logic       gate_motor,
    output logic       full_lamp,
    output logic       busy
);

    // Debounce threshold, widened by one bit so count+1 cannot wrap.
    localparam logic [4:0] DbTarget = 5'(DEBOUNCE);
    localparam logic [7:0] HoldInit = 8'(DOOR_HOLD);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StOpen,
        StClear
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic       ent_stable_q, ent_stable_d;
    logic [3:0] ent_cnt_q, ent_cnt_d;
    logic       ext_stable_q, ext_stable_d;
    logic [3:0] ext_cnt_q, ext_cnt_d;

    logic       entry_pend_q, entry_pend_d;
    logic       exit_pend_q, exit_pend_d;
    logic [1:0] exit_slot_q, exit_slot_d;

    state_e     state_q, state_d;
    logic       dir_q, dir_d;  // 0: serving entry, 1: serving exit
    logic [7:0] hold_q, hold_d;

    logic       entry_signal_q, entry_signal_d;
    logic       exit_signal_q, exit_signal_d;
    logic       gate_motor_q, gate_motor_d;
    logic       full_lamp_q, full_lamp_d;
    logic       busy_q, busy_d;

    // Debounce events
    logic       ent_differs, ent_flip, ent_rise, ent_fall;
    logic       ext_differs, ext_flip, ext_rise;

    // Decision raised in WAIT for a rejected entry
    logic       lamp_set;

    // ------------------------------------------------------------------
    // Entry sensor debounce: count samples that disagree with the stable level
    // ------------------------------------------------------------------
    always_comb begin
        ent_differs  = entry_sensor != ent_stable_q;
        ent_flip     = ent_differs && (({1'b0, ent_cnt_q} + 5'd1) == DbTarget);
        ent_rise     = ent_flip && !ent_stable_q;
        ent_fall     = ent_flip && ent_stable_q;
        ent_stable_d = ent_flip ? !ent_stable_q : ent_stable_q;
        if (!ent_differs || ent_flip) begin
            ent_cnt_d = 4'd0;
        end else begin
            ent_cnt_d = ent_cnt_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Exit sensor debounce: same scheme as the entry side
    // ------------------------------------------------------------------
    always_comb begin
        ext_differs  = exit_sensor != ext_stable_q;
        ext_flip     = ext_differs && (({1'b0, ext_cnt_q} + 5'd1) == DbTarget);
        ext_rise     = ext_flip && !ext_stable_q;
        ext_stable_d = ext_flip ? !ext_stable_q : ext_stable_q;
        if (!ext_differs || ext_flip) begin
            ext_cnt_d = 4'd0;
        end else begin
            ext_cnt_d = ext_cnt_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // One-deep pending flags; the slot is captured only when the exit flag sets
    // ------------------------------------------------------------------
    always_comb begin
        entry_pend_d = entry_pend_q;
        exit_pend_d  = exit_pend_q;
        exit_slot_d  = exit_slot_q;

        if (ent_rise) begin
            entry_pend_d = 1'b1;
        end
        if (ext_rise && !exit_pend_q) begin
            exit_pend_d = 1'b1;
            exit_slot_d = exit_request_slot;
        end

        // The request leaves ISSUE: retire the flag it was serving.
        if (state_q == StIssue) begin
            if (dir_q) begin
                exit_pend_d = 1'b0;
            end else begin
                entry_pend_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        hold_d   = hold_q;
        lamp_set = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (entry_pend_q) begin
                    state_d = StIssue;
                    dir_d   = 1'b0;
                end else if (exit_pend_q) begin
                    state_d = StIssue;
                    dir_d   = 1'b1;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (is_open) begin
                    state_d = StOpen;
                    hold_d  = HoldInit;
                end else begin
                    // Rejected entry lights the lamp; an unanswered request
                    // or an exit of an empty slot simply gives up.
                    lamp_set = !dir_q && is_full;
                    state_d  = StIdle;
                end
            end
            StOpen: begin
                hold_d = hold_q - 8'd1;
                if (hold_q == 8'd1) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                // Wait for the served car to leave its sensor.
                if (!(dir_q ? ext_stable_q : ent_stable_q)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, derived from the state being entered
    // ------------------------------------------------------------------
    always_comb begin
        entry_signal_d = (state_d == StIssue) && !dir_d;
        exit_signal_d  = (state_d == StIssue) && dir_d;
        gate_motor_d   = state_d == StOpen;
        busy_d         = state_d != StIdle;

        full_lamp_d = full_lamp_q;
        if (ent_fall) begin
            full_lamp_d = 1'b0;
        end
        // Only light the lamp while a car is still in the entry lane.
        if (lamp_set && ent_stable_d) begin
            full_lamp_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers with synchronous reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_stable_q   <= 1'b0;
            ent_cnt_q      <= 4'd0;
            ext_stable_q   <= 1'b0;
            ext_cnt_q      <= 4'd0;
            entry_pend_q   <= 1'b0;
            exit_pend_q    <= 1'b0;
            exit_slot_q    <= 2'd0;
            state_q        <= StIdle;
            dir_q          <= 1'b0;
            hold_q         <= 8'd0;
            entry_signal_q <= 1'b0;
            exit_signal_q  <= 1'b0;
            gate_motor_q   <= 1'b0;
            full_lamp_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            ent_stable_q   <= ent_stable_d;
            ent_cnt_q      <= ent_cnt_d;
            ext_stable_q   <= ext_stable_d;
            ext_cnt_q      <= ext_cnt_d;
            entry_pend_q   <= entry_pend_d;
            exit_pend_q    <= exit_pend_d;
            exit_slot_q    <= exit_slot_d;
            state_q        <= state_d;
            dir_q          <= dir_d;
            hold_q         <= hold_d;
            entry_signal_q <= entry_signal_d;
            exit_signal_q  <= exit_signal_d;
            gate_motor_q   <= gate_motor_d;
            full_lamp_q    <= full_lamp_d;
            busy_q         <= busy_d;
        end
    end

    assign entry_signal = entry_signal_q;
    assign exit_signal  = exit_signal_q;
    assign exit_slot    = exit_slot_q;
    assign gate_motor   = gate_motor_q;
    assign full_lamp    = full_lamp_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_gate_controller.sv
// Directed bench for gate_controller with a small occupancy FSM model.
// Edge numbering: "edge e" is the e-th rising edge after the scenario starts;
// outputs are sampled 1 ns after that edge.
module tb_gate_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       entry_sensor;
    logic       exit_sensor;
    logic [1:0] exit_request_slot;
    logic       is_open = 1'b0;
    logic       is_full = 1'b0;
    logic       entry_signal;
    logic       exit_signal;
    logic [1:0] exit_slot;
    logic       gate_motor;
    logic       full_lamp;
    logic       busy;

    // 0: no response, 1: is_open, 2: is_full
    logic [1:0] resp_mode;

    int tests  = 0;
    int errors = 0;

    gate_controller #(
        .DEBOUNCE (4),
        .DOOR_HOLD(8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .entry_sensor     (entry_sensor),
        .exit_sensor      (exit_sensor),
        .exit_request_slot(exit_request_slot),
        .is_open          (is_open),
        .is_full          (is_full),
        .entry_signal     (entry_signal),
        .exit_signal      (exit_signal),
        .exit_slot        (exit_slot),
        .gate_motor       (gate_motor),
        .full_lamp        (full_lamp),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Occupancy FSM model: one-cycle response registered one edge after a request.
    always @(posedge clk) begin
        is_open <= (entry_signal || exit_signal) && (resp_mode == 2'd1);
        is_full <= (entry_signal || exit_signal) && (resp_mode == 2'd2);
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        entry_sensor      = 1'b0;
        exit_sensor       = 1'b0;
        exit_request_slot = 2'd0;
        resp_mode         = 2'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_entry", 8'(entry_signal), 8'd0);
        check("rst_exit", 8'(exit_signal), 8'd0);
        check("rst_slot", 8'(exit_slot), 8'd0);
        check("rst_motor", 8'(gate_motor), 8'd0);
        check("rst_lamp", 8'(full_lamp), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);

        // 1: accepted entry
        resp_mode    = 2'd1;
        entry_sensor = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            check("s1_entry", 8'(entry_signal), 8'(e == 5));
            check("s1_exit", 8'(exit_signal), 8'd0);
            check("s1_motor", 8'(gate_motor), 8'(e >= 7 && e <= 14));
            check("s1_busy", 8'(busy), 8'(e >= 5));
            check("s1_lamp", 8'(full_lamp), 8'd0);
        end
        entry_sensor = 1'b0;
        for (int e = 17; e <= 22; e++) begin
            step();
            check("s1_busy_drop", 8'(busy), 8'(e <= 20));
        end

        // 2: glitch shorter than the debounce window
        do_reset();
        entry_sensor = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 3) entry_sensor = 1'b0;
            check("s2_entry", 8'(entry_signal), 8'd0);
            check("s2_busy", 8'(busy), 8'd0);
        end

        // 3: rejected entry (no reset: also proves the glitch left no count behind)
        resp_mode    = 2'd2;
        entry_sensor = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            check("s3_entry", 8'(entry_signal), 8'(e == 5));
            check("s3_lamp", 8'(full_lamp), 8'(e >= 7));
            check("s3_motor", 8'(gate_motor), 8'd0);
            check("s3_busy", 8'(busy), 8'(e == 5 || e == 6));
        end
        entry_sensor = 1'b0;
        for (int e = 13; e <= 17; e++) begin
            step();
            check("s3_lamp_off", 8'(full_lamp), 8'(e < 16));
        end

        // 4: simultaneous entry and exit; entry served first
        do_reset();
        resp_mode         = 2'd1;
        entry_sensor      = 1'b1;
        exit_sensor       = 1'b1;
        exit_request_slot = 2'b10;
        for (int e = 1; e <= 38; e++) begin
            step();
            if (e == 4) exit_request_slot = 2'b01;
            if (e == 15) entry_sensor = 1'b0;
            if (e == 32) exit_sensor = 1'b0;
            check("s4_entry", 8'(entry_signal), 8'(e == 5));
            check("s4_exit", 8'(exit_signal), 8'(e == 21));
            check("s4_both", 8'(entry_signal & exit_signal), 8'd0);
            check("s4_slot", 8'(exit_slot), (e >= 4) ? 8'd2 : 8'd0);
            check("s4_motor", 8'(gate_motor),
                  8'((e >= 7 && e <= 14) || (e >= 23 && e <= 30)));
            check("s4_busy", 8'(busy), 8'((e >= 5 && e <= 19) || (e >= 21 && e <= 36)));
        end

        // 5: exit with no response from the occupancy FSM
        do_reset();
        resp_mode         = 2'd0;
        exit_sensor       = 1'b1;
        exit_request_slot = 2'b11;
        for (int e = 1; e <= 10; e++) begin
            step();
            check("s5_exit", 8'(exit_signal), 8'(e == 5));
            check("s5_slot", 8'(exit_slot), (e >= 4) ? 8'd3 : 8'd0);
            check("s5_busy", 8'(busy), 8'(e == 5 || e == 6));
            check("s5_motor", 8'(gate_motor), 8'd0);
        end

        // 6: reset during the hold with an exit still pending
        do_reset();
        resp_mode         = 2'd1;
        entry_sensor      = 1'b1;
        exit_sensor       = 1'b1;
        exit_request_slot = 2'b01;
        for (int e = 1; e <= 10; e++) begin
            step();
            check("s6_motor", 8'(gate_motor), 8'(e >= 7));
            check("s6_slot", 8'(exit_slot), (e >= 4) ? 8'd1 : 8'd0);
        end
        reset        = 1'b1;
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        step();
        check("s6_rst_motor", 8'(gate_motor), 8'd0);
        check("s6_rst_busy", 8'(busy), 8'd0);
        check("s6_rst_slot", 8'(exit_slot), 8'd0);
        reset = 1'b0;
        for (int e = 12; e <= 25; e++) begin
            step();
            check("s6_no_exit", 8'(exit_signal), 8'd0);
            check("s6_no_entry", 8'(entry_signal), 8'd0);
            check("s6_idle", 8'(busy), 8'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
